// File: rtl/decode_pipe_pkg.sv
// Shared opcode/funct encodings and field widths for the MIPS decode pipeline.
// DECODE_SHIFT_EN adds SLL/SRL/SRA to the legal R-type functs.
package decode_pipe_pkg;

   localparam int OPCODE_WIDTH = 6;
   localparam int FUNCT_WIDTH  = 6;
   localparam int JADDR_WIDTH  = 26;
   localparam int SHAMT_WIDTH  = 5;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'h02;
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = 6'h09;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU = 6'h0B;
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
   localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'h0E;
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 6'h23;
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 6'h2B;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OP_BEQ;

   localparam logic [FUNCT_WIDTH-1:0] FN_SLL  = 6'h00;
   localparam logic [FUNCT_WIDTH-1:0] FN_SRL  = 6'h02;
   localparam logic [FUNCT_WIDTH-1:0] FN_SRA  = 6'h03;
   localparam logic [FUNCT_WIDTH-1:0] FN_ADD  = 6'h20;
   localparam logic [FUNCT_WIDTH-1:0] FN_ADDU = 6'h21;
   localparam logic [FUNCT_WIDTH-1:0] FN_SUB  = 6'h22;
   localparam logic [FUNCT_WIDTH-1:0] FN_SUBU = 6'h23;
   localparam logic [FUNCT_WIDTH-1:0] FN_AND  = 6'h24;
   localparam logic [FUNCT_WIDTH-1:0] FN_OR   = 6'h25;
   localparam logic [FUNCT_WIDTH-1:0] FN_XOR  = 6'h26;
   localparam logic [FUNCT_WIDTH-1:0] FN_NOR  = 6'h27;
   localparam logic [FUNCT_WIDTH-1:0] FN_SLT  = 6'h2A;
   localparam logic [FUNCT_WIDTH-1:0] FN_SLTU = 6'h2B;

   function automatic logic rfunct_legal(input logic [FUNCT_WIDTH-1:0] fn);
      case (fn)
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
         FN_XOR, FN_NOR, FN_SLT, FN_SLTU: rfunct_legal = 1'b1;
`ifdef DECODE_SHIFT_EN
         FN_SLL, FN_SRL, FN_SRA:          rfunct_legal = 1'b1;
`endif
         default:                         rfunct_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/decode_pipe_comb.sv
// Purely combinational MIPS instruction-to-bundle decoder.
// DECODE_SHIFT_EN adds the shamt field output.
module decode_comb
   import decode_pipe_pkg::*;
#(
   parameter int AWIDTH    = 5,
   parameter int IWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int IMM_WIDTH = 16
) (
   input  logic [IWIDTH-1:0]       instr_i,
   output logic [OPCODE_WIDTH-1:0] opcode_o,
   output logic [FUNCT_WIDTH-1:0]  funct_o,
   output logic [AWIDTH-1:0]       addr_rs_o,
   output logic [AWIDTH-1:0]       addr_rt_o,
   output logic [AWIDTH-1:0]       addr_rd_o,
   output logic [DWIDTH-1:0]       imm_o,
   output logic [JADDR_WIDTH-1:0]  jaddr_o,
`ifdef DECODE_SHIFT_EN
   output logic [SHAMT_WIDTH-1:0]  shamt_o,
`endif
   output logic                    we_o,
   output logic                    mem_rd_o,
   output logic                    mem_wr_o,
   output logic                    branch_o,
   output logic                    jump_o,
   output logic                    illegal_o
);

   logic [DWIDTH-1:0] imm_sext;
   logic [DWIDTH-1:0] imm_zext;

   assign imm_sext  = {{(DWIDTH-IMM_WIDTH){instr_i[IMM_WIDTH-1]}}, instr_i[IMM_WIDTH-1:0]};
   assign imm_zext  = {{(DWIDTH-IMM_WIDTH){1'b0}}, instr_i[IMM_WIDTH-1:0]};
   assign opcode_o  = instr_i[31:26];
   assign addr_rs_o = instr_i[21 +: AWIDTH];
   assign addr_rt_o = instr_i[16 +: AWIDTH];

   always_comb begin
      funct_o   = '0;
      addr_rd_o = '0;
      imm_o     = '0;
      jaddr_o   = '0;
`ifdef DECODE_SHIFT_EN
      shamt_o   = '0;
`endif
      we_o      = 1'b0;
      mem_rd_o  = 1'b0;
      mem_wr_o  = 1'b0;
      branch_o  = 1'b0;
      jump_o    = 1'b0;
      illegal_o = 1'b0;
      case (instr_i[31:26])
         OP_RTYPE: begin
            funct_o   = instr_i[5:0];
            addr_rd_o = instr_i[11 +: AWIDTH];
`ifdef DECODE_SHIFT_EN
            shamt_o   = instr_i[10:6];
`endif
            // an unknown funct still yields fields, but no side effects
            we_o      = rfunct_legal(instr_i[5:0]);
            illegal_o = !rfunct_legal(instr_i[5:0]);
         end
         OP_LOAD: begin
            addr_rd_o = instr_i[16 +: AWIDTH];
            imm_o     = imm_sext;
            we_o      = 1'b1;
            mem_rd_o  = 1'b1;
         end
         OP_STORE: begin
            imm_o    = imm_sext;
            mem_wr_o = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            imm_o    = imm_sext;
            branch_o = 1'b1;
         end
         OP_J: begin
            jaddr_o = instr_i[JADDR_WIDTH-1:0];
            jump_o  = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            addr_rd_o = instr_i[16 +: AWIDTH];
            imm_o     = imm_sext;
            we_o      = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            addr_rd_o = instr_i[16 +: AWIDTH];
            imm_o     = imm_zext;
            we_o      = 1'b1;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_pipe.sv
// MIPS decode stage with valid/ready handshakes and a 2-entry OUT/SKID buffer.
// DECODE_SHIFT_EN adds dp_o_shamt and legalises SLL/SRL/SRA.
module decode_pipe
   import decode_pipe_pkg::*;
#(
   parameter int AWIDTH    = 5,
   parameter int IWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int IMM_WIDTH = 16,
   parameter int PCWIDTH   = 32
) (
   input  logic                    dp_clk,
   input  logic                    dp_rst,
   input  logic                    dp_i_valid,
   output logic                    dp_o_ready,
   input  logic [IWIDTH-1:0]       dp_i_instr,
   input  logic [PCWIDTH-1:0]      dp_i_pc,
   input  logic                    dp_i_flush,
   output logic                    dp_o_valid,
   input  logic                    dp_i_ready,
   output logic [PCWIDTH-1:0]      dp_o_pc,
   output logic [OPCODE_WIDTH-1:0] dp_o_opcode,
   output logic [FUNCT_WIDTH-1:0]  dp_o_funct,
   output logic [AWIDTH-1:0]       dp_o_addr_rs,
   output logic [AWIDTH-1:0]       dp_o_addr_rt,
   output logic [AWIDTH-1:0]       dp_o_addr_rd,
   output logic [DWIDTH-1:0]       dp_o_imm,
   output logic [JADDR_WIDTH-1:0]  dp_o_jaddr,
`ifdef DECODE_SHIFT_EN
   output logic [SHAMT_WIDTH-1:0]  dp_o_shamt,
`endif
   output logic                    dp_o_we,
   output logic                    dp_o_mem_rd,
   output logic                    dp_o_mem_wr,
   output logic                    dp_o_branch,
   output logic                    dp_o_jump,
   output logic                    dp_o_illegal
);

`ifdef DECODE_SHIFT_EN
   localparam int SH_W = SHAMT_WIDTH;
`else
   localparam int SH_W = 0;
`endif
   localparam int BW = PCWIDTH + OPCODE_WIDTH + FUNCT_WIDTH + 3*AWIDTH + DWIDTH
                       + JADDR_WIDTH + SH_W + 6;

   logic [OPCODE_WIDTH-1:0] c_opcode;
   logic [FUNCT_WIDTH-1:0]  c_funct;
   logic [AWIDTH-1:0]       c_rs, c_rt, c_rd;
   logic [DWIDTH-1:0]       c_imm;
   logic [JADDR_WIDTH-1:0]  c_jaddr;
   logic                    c_we, c_mem_rd, c_mem_wr, c_branch, c_jump, c_illegal;
`ifdef DECODE_SHIFT_EN
   logic [SHAMT_WIDTH-1:0]  c_shamt;
`endif

   decode_comb #(
      .AWIDTH    (AWIDTH),
      .IWIDTH    (IWIDTH),
      .DWIDTH    (DWIDTH),
      .IMM_WIDTH (IMM_WIDTH)
   ) u_decode_comb (
      .instr_i   (dp_i_instr),
      .opcode_o  (c_opcode),
      .funct_o   (c_funct),
      .addr_rs_o (c_rs),
      .addr_rt_o (c_rt),
      .addr_rd_o (c_rd),
      .imm_o     (c_imm),
      .jaddr_o   (c_jaddr),
`ifdef DECODE_SHIFT_EN
      .shamt_o   (c_shamt),
`endif
      .we_o      (c_we),
      .mem_rd_o  (c_mem_rd),
      .mem_wr_o  (c_mem_wr),
      .branch_o  (c_branch),
      .jump_o    (c_jump),
      .illegal_o (c_illegal)
   );

   logic [BW-1:0] new_bundle;
   logic [BW-1:0] out_q, out_d, skid_q, skid_d;
   logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
   logic          consume, accept;

   assign new_bundle = {dp_i_pc, c_opcode, c_funct, c_rs, c_rt, c_rd, c_imm, c_jaddr,
`ifdef DECODE_SHIFT_EN
                        c_shamt,
`endif
                        c_we, c_mem_rd, c_mem_wr, c_branch, c_jump, c_illegal};

   assign consume = out_vld_q & dp_i_ready;
   assign accept  = dp_i_valid & rdy_q;

   always_comb begin
      out_d      = out_q;
      skid_d     = skid_q;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      if (dp_i_flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (consume && skid_vld_q) begin
         out_d      = skid_q;
         out_vld_d  = 1'b1;
         skid_vld_d = accept;
         if (accept) skid_d = new_bundle;
      end else if (!out_vld_q || consume) begin
         // OUT is free (or draining this edge): refill it or go empty
         out_vld_d = accept;
         if (accept) out_d = new_bundle;
      end else if (accept) begin
         skid_d     = new_bundle;
         skid_vld_d = 1'b1;
      end
      rdy_d = !skid_vld_d;
   end

   // Control state: async reset.
   always_ff @(posedge dp_clk or negedge dp_rst) begin
      if (!dp_rst) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= rdy_d;
      end
   end

   // Data payload: no reset, masked at the outputs while invalid.
   always_ff @(posedge dp_clk) begin
      out_q  <= out_d;
      skid_q <= skid_d;
   end

   assign dp_o_ready = rdy_q;
   assign dp_o_valid = out_vld_q;
   assign {dp_o_pc, dp_o_opcode, dp_o_funct, dp_o_addr_rs, dp_o_addr_rt, dp_o_addr_rd,
           dp_o_imm, dp_o_jaddr,
`ifdef DECODE_SHIFT_EN
           dp_o_shamt,
`endif
           dp_o_we, dp_o_mem_rd, dp_o_mem_wr, dp_o_branch, dp_o_jump, dp_o_illegal}
          = out_vld_q ? out_q : '0;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed-vector bench for decode_pipe: decode fields, backpressure, flush, async reset.
module tb_decode_pipe;
   import decode_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_instr = '0;
   logic [31:0] i_pc = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_pc;
   logic [5:0]  o_opcode, o_funct;
   logic [4:0]  o_rs, o_rt, o_rd;
   logic [31:0] o_imm;
   logic [25:0] o_jaddr;
   logic        o_we, o_mem_rd, o_mem_wr, o_branch, o_jump, o_illegal;
`ifdef DECODE_SHIFT_EN
   logic [4:0]  o_shamt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_pipe dut (
      .dp_clk       (clk),
      .dp_rst       (rst_n),
      .dp_i_valid   (i_valid),
      .dp_o_ready   (o_ready),
      .dp_i_instr   (i_instr),
      .dp_i_pc      (i_pc),
      .dp_i_flush   (i_flush),
      .dp_o_valid   (o_valid),
      .dp_i_ready   (i_ready),
      .dp_o_pc      (o_pc),
      .dp_o_opcode  (o_opcode),
      .dp_o_funct   (o_funct),
      .dp_o_addr_rs (o_rs),
      .dp_o_addr_rt (o_rt),
      .dp_o_addr_rd (o_rd),
      .dp_o_imm     (o_imm),
      .dp_o_jaddr   (o_jaddr),
`ifdef DECODE_SHIFT_EN
      .dp_o_shamt   (o_shamt),
`endif
      .dp_o_we      (o_we),
      .dp_o_mem_rd  (o_mem_rd),
      .dp_o_mem_wr  (o_mem_wr),
      .dp_o_branch  (o_branch),
      .dp_o_jump    (o_jump),
      .dp_o_illegal (o_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
      i_valid = 1'b1;
      i_instr = ins;
      i_pc    = pc;
   endtask

   task automatic chk_ctrl(input string tag, input logic [5:0] exp);
      chk(tag, {58'd0, o_we, o_mem_rd, o_mem_wr, o_branch, o_jump, o_illegal}, {58'd0, exp});
   endtask

   initial begin
      #2;
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 0);
      chk("rst_imm", o_imm, 0);
      #5 rst_n = 1'b1;
      tick();
      chk("ready_after_rst", o_ready, 1);

      // addi $8,$9,-1
      i_ready = 1'b1;
      offer(32'h2128FFFF, 32'h1000);
      tick();
      chk("addi_valid", o_valid, 1);
      chk("addi_rs", o_rs, 9);
      chk("addi_rt", o_rt, 8);
      chk("addi_rd", o_rd, 8);
      chk("addi_imm", o_imm, 32'hFFFFFFFF);
      chk("addi_pc", o_pc, 32'h1000);
      chk_ctrl("addi_ctrl", 6'b100000);

      offer(32'h35288000, 32'h1004);
      tick();
      chk("ori_imm", o_imm, 32'h00008000);
      chk_ctrl("ori_ctrl", 6'b100000);

      offer(32'h00221820, 32'h1008);
      tick();
      chk("add_rd", o_rd, 3);
      chk("add_funct", o_funct, 6'h20);
      chk("add_imm", o_imm, 0);
      chk_ctrl("add_ctrl", 6'b100000);

      offer(32'hACC50004, 32'h100C);
      tick();
      chk("sw_rd", o_rd, 0);
      chk("sw_imm", o_imm, 4);
      chk_ctrl("sw_ctrl", 6'b001000);

      offer(32'hFC000000, 32'h1010);
      tick();
      chk("ill_valid", o_valid, 1);
      chk_ctrl("ill_ctrl", 6'b000001);

      // lw $4,-8($2): load sign-extends
      offer(32'h8C44FFF8, 32'h1014);
      tick();
      chk("lw_imm", o_imm, 32'hFFFFFFF8);
      chk("lw_rd", o_rd, 4);
      chk_ctrl("lw_ctrl", 6'b110000);

      // beq $1,$2,0x10 / j 0x0123456
      offer(32'h10220010, 32'h1018);
      tick();
      chk_ctrl("beq_ctrl", 6'b000100);
      chk("beq_imm", o_imm, 32'h10);
      offer(32'h08123456, 32'h101C);
      tick();
      chk_ctrl("j_ctrl", 6'b000010);
      chk("j_jaddr", o_jaddr, 26'h0123456);
      chk("j_imm", o_imm, 0);

      // sll $2,$2,2
      offer(32'h00021080, 32'h1020);
      tick();
`ifdef DECODE_SHIFT_EN
      chk_ctrl("sll_ctrl", 6'b100000);
      chk("sll_shamt", o_shamt, 2);
`else
      chk_ctrl("sll_ctrl", 6'b000001);
`endif
      chk("sll_rd", o_rd, 2);

      i_valid = 1'b0;
      tick();
      chk("idle_valid", o_valid, 0);
      chk("idle_imm", o_imm, 0);

      // Backpressure: three back-to-back offers with downstream stalled
      i_ready = 1'b0;
      offer(32'h21010001, 32'h100);
      tick();
      chk("bp_ready1", o_ready, 1);
      offer(32'h21010002, 32'h104);
      tick();
      chk("bp_ready2", o_ready, 0);
      offer(32'h21010003, 32'h108);
      tick();
      chk("bp_hold_pc", o_pc, 32'h100);
      chk("bp_ready3", o_ready, 0);
      i_ready = 1'b1;
      tick();
      chk("bp_out1_pc", o_pc, 32'h104);
      chk("bp_out1_imm", o_imm, 2);
      chk("bp_ready4", o_ready, 1);
      tick();
      chk("bp_out2_pc", o_pc, 32'h108);
      chk("bp_out2_imm", o_imm, 3);
      chk("bp_out2_valid", o_valid, 1);
      i_valid = 1'b0;
      tick();
      chk("bp_drain_valid", o_valid, 0);

      // Flush with OUT and SKID full and an input presented
      i_ready = 1'b0;
      offer(32'h21010011, 32'h200);
      tick();
      offer(32'h21010012, 32'h204);
      tick();
      chk("fl_full_ready", o_ready, 0);
      offer(32'h21010013, 32'h208);
      i_flush = 1'b1;
      tick();
      chk("fl_valid", o_valid, 0);
      chk("fl_ready", o_ready, 1);
      // flush while ready: the presented word must be dropped
      offer(32'h21010014, 32'h20C);
      tick();
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      chk("fl_drop_valid", o_valid, 0);
      tick();
      chk("fl_after_valid", o_valid, 0);

      // Asynchronous reset between edges
      offer(32'h2128FFFF, 32'h300);
      tick();
      chk("ar_pre_valid", o_valid, 1);
      i_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", o_valid, 0);
      chk("ar_imm", o_imm, 0);
      chk("ar_ready", o_ready, 0);
      #3 rst_n = 1'b1;
      tick();
      chk("ar_ready_after", o_ready, 1);
      offer(32'h35288000, 32'h304);
      tick();
      chk("ar_first_valid", o_valid, 1);
      chk("ar_first_imm", o_imm, 32'h00008000);
      chk("ar_first_pc", o_pc, 32'h304);
      i_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised successor of the single-register instruction decoder.
- Sits between fetch and register-read/execute.
- Decodes one 32-bit MIPS instruction per cycle into fields plus control flags: sign/zero-extended immediate, write-back destination select, memory, branch and jump flags, illegal flag, PC pass-through.
- Uses valid/ready handshakes on both sides with a 2-entry skid buffer, so it runs at full throughput under backpressure. Supports a synchronous pipeline flush.

Parameters:
- AWIDTH, 5, register address width.
- IWIDTH, 32, instruction width (fixed-format MIPS; only 32 is legal).
- DWIDTH, 32, width of the extended immediate output.
- IMM_WIDTH, 16, raw immediate field width.
- PCWIDTH, 32, program-counter width carried alongside each instruction.

Ports:
- dp_clk  in  1  clock, rising edge.
- dp_rst  in  1  asynchronous active-low reset.
- dp_i_valid  in  1  instruction/PC present.
- dp_o_ready  out  1  decoder can accept this cycle.
- dp_i_instr  in  IWIDTH  instruction word.
- dp_i_pc  in  PCWIDTH  PC of the instruction.
- dp_i_flush  in  1  discard all held and incoming instructions.
- dp_o_valid  out  1  decoded bundle valid.
- dp_i_ready  in  1  downstream accepts the bundle.
- dp_o_pc  out  PCWIDTH  PC of the bundle.
- dp_o_opcode  out  OPCODE_WIDTH  instr[31:26].
- dp_o_funct  out  FUNCT_WIDTH  instr[5:0] for R-type, else 0.
- dp_o_addr_rs  out  AWIDTH  instr[25:21].
- dp_o_addr_rt  out  AWIDTH  instr[20:16].
- dp_o_addr_rd  out  AWIDTH  write-back destination: instr[15:11] for R-type, instr[20:16] for load/ALU-immediate, else 0.
- dp_o_imm  out  DWIDTH  extended immediate.
- dp_o_jaddr  out  26  instr[25:0] for J, else 0.
- dp_o_we  out  1  register write-back.
- dp_o_mem_rd  out  1  load.
- dp_o_mem_wr  out  1  store.
- dp_o_branch  out  1  BEQ/BNE.
- dp_o_jump  out  1  J.
- dp_o_illegal  out  1  unrecognised opcode, or R-type with unrecognised funct.

Behaviour:
- Reset (dp_rst low, asynchronous):
  - All outputs 0, including dp_o_valid.
  - dp_o_ready reads 1 from the first edge after release.
  - Both buffer entries are invalid.
- Decode is combinational on dp_i_instr and is captured at acceptance. Acceptance = dp_i_valid & dp_o_ready.
- Storage: output register OUT plus skid register SKID.
  - dp_o_ready = !SKID.valid (registered; no combinational path from dp_i_ready).
- Per rising edge, with consume = OUT.valid & dp_i_ready:
  - If flush: OUT.valid = 0 and SKID.valid = 0. Any input presented that cycle is dropped. Flush beats every other event.
  - Else if consume and SKID.valid: OUT <= SKID. If an input is accepted, SKID <= new; otherwise SKID.valid = 0.
  - Else if (!OUT.valid or consume) and an input is accepted: OUT <= new.
  - Else if OUT.valid, not consume, and an input is accepted: SKID <= new.
  - Else: hold.
- Latency and ordering:
  - Latency is 1 cycle from acceptance to dp_o_valid when OUT is free.
  - Throughput is 1 per cycle while dp_i_ready stays high.
  - Order is strictly preserved.
- Bundle contents while dp_o_valid = 0 are don't-care. The implementation drives them to 0.
- Immediate extension:
  - Sign-extend instr[15:0] to DWIDTH for LOAD, STORE, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU.
  - Zero-extend for ANDI, ORI, XORI.
  - 0 for R-type and J.
- Control flags:
  - we = 1 for R-type with legal funct, LOAD, and ALU-immediate.
  - An illegal instruction still produces a valid bundle, with illegal = 1 and we, mem_rd, mem_wr, branch and jump all 0.
- Legal R-type functs: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU.

Optional Feature:
- Macro: DECODE_SHIFT_EN.
- Defined:
  - Adds output dp_o_shamt (5 bits) = instr[10:6] for R-type, else 0.
  - SLL, SRL and SRA become legal R-type functs with we = 1.
- Undefined:
  - No dp_o_shamt port.
  - SLL, SRL and SRA decode as illegal.

Decomposition:
- header.vh holds OPCODE_WIDTH, FUNCT_WIDTH, all opcode defines (RTYPE, LOAD, STORE, BRANCH=BEQ, BNE, J, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI) and all funct defines, including SLL/SRL/SRA.
- One sub-module: decode_comb, the purely combinational instruction to bundle decoder.
- decode_pipe instantiates it and implements the OUT/SKID handshake.

Test Plan:
- addi $8,$9,-1 (0x2128FFFF), dp_i_ready = 1 -> next cycle: valid = 1, rs = 9, rt = 8, rd = 8, imm = 0xFFFFFFFF, we = 1, illegal = 0.
- ori $8,$9,0x8000 (0x35288000) -> imm = 0x00008000. Then add $3,$1,$2 (0x00221820) -> rd = 3, funct = 0x20, imm = 0, we = 1.
- sw $5,4($6) (0xACC50004) -> mem_wr = 1, we = 0, rd = 0, imm = 4. Word 0xFC000000 -> valid = 1, illegal = 1, all control flags 0.
- Backpressure: dp_i_ready = 0, offer 3 back-to-back instructions -> first two accepted, dp_o_ready = 0 on the third. Release dp_i_ready -> all three emerge in order, one per cycle, with none lost or duplicated.
- Flush with OUT and SKID full and dp_i_valid = 1 -> next cycle dp_o_valid = 0, dp_o_ready = 1, the presented instruction is never emitted.
- Assert dp_rst low mid-stream, asynchronously between edges -> outputs 0 immediately. After release, the first accepted instruction decodes correctly.
